// File: rtl/rob_commit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rob_commit_pkg : shared widths and constants for the reorder buffer slice.
// Rev 1.0
// ----------------------------------------------------------------------------
package rob_commit_pkg;
  localparam int RegAddrSize = 5;
  localparam int InstSize    = 32;
  // Tag value one past the last real entry; consumers read it as "no dependency".
  localparam logic [RegAddrSize:0] MAXN = 6'd32;
  localparam logic ZERO = 1'b0;
  localparam logic ONE  = 1'b1;
endpackage
`default_nettype wire

// File: rtl/rob_ptr_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rob_ptr_ctrl : head/tail/occupancy bookkeeping for the reorder buffer.
// Rev 1.0
// ----------------------------------------------------------------------------
module rob_ptr_ctrl #(
  parameter int DEPTH       = 32,
  parameter int TAG_W       = 5,
  parameter int FULL_MARGIN = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             alloc_fire,
  input  logic             commit_fire,
  input  logic             flush,
  output logic [TAG_W-1:0] head,
  output logic [TAG_W-1:0] tail,
  output logic [TAG_W:0]   count,
  output logic             full
);
  localparam int CW = TAG_W + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH - FULL_MARGIN);

  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (commit_fire) head_d = head_q + TAG_W'(1);
      if (alloc_fire)  tail_d = tail_q + TAG_W'(1);
      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = head_q;
  assign tail  = tail_q;
  assign count = count_q;
  assign full  = (count_q >= FULL_LVL);
endmodule
`default_nettype wire

// File: rtl/rob_commit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rob_commit : reorder buffer with in-order commit broadcast and flush on
//              mispredicted retire.  Rev 1.0
// ----------------------------------------------------------------------------
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int TAG_W       = RegAddrSize,
  parameter int FULL_MARGIN = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   alloc_en,
  input  logic [RegAddrSize-1:0] alloc_rd,
  input  logic                   alloc_has_rd,
  output logic [TAG_W-1:0]       alloc_tag,
  output logic                   rob_is_full,
  input  logic [TAG_W-1:0]       q1_tag,
  input  logic [TAG_W-1:0]       q2_tag,
  output logic                   q1_ready,
  output logic                   q2_ready,
  output logic [InstSize-1:0]    q1_val,
  output logic [InstSize-1:0]    q2_val,
  input  logic                   wb_en,
  input  logic [TAG_W-1:0]       wb_tag,
  input  logic [InstSize-1:0]    wb_val,
  input  logic                   wb_mispredict,
  input  logic [InstSize-1:0]    wb_target,
  output logic                   commit_en,
  output logic [TAG_W-1:0]       commit_Number,
  output logic [InstSize-1:0]    commit_val,
  output logic [RegAddrSize-1:0] commit_rd,
  output logic                   commit_has_rd,
  output logic                   clear,
  output logic [InstSize-1:0]    clear_pc
);
  localparam int CW = TAG_W + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [TAG_W-1:0] head, tail;
  logic [CW-1:0]    count;
  logic             alloc_fire, wb_fire, commit_fire, flush;

  logic [DEPTH-1:0]       valid_q, valid_d, ready_q, ready_d;
  logic [DEPTH-1:0]       mis_q, mis_d, has_rd_q, has_rd_d;
  logic [RegAddrSize-1:0] rd_q [DEPTH];
  logic [RegAddrSize-1:0] rd_d [DEPTH];
  logic [InstSize-1:0]    val_q [DEPTH];
  logic [InstSize-1:0]    val_d [DEPTH];
  logic [InstSize-1:0]    target_q [DEPTH];
  logic [InstSize-1:0]    target_d [DEPTH];

  logic                   commit_en_q, commit_en_d, commit_has_rd_q, commit_has_rd_d;
  logic [TAG_W-1:0]       commit_num_q, commit_num_d;
  logic [InstSize-1:0]    commit_val_q, commit_val_d;
  logic [RegAddrSize-1:0] commit_rd_q, commit_rd_d;
  logic                   clear_q, clear_d;
  logic [InstSize-1:0]    clear_pc_q, clear_pc_d;

  // The cycle after a flush belongs to the redirect: ISSUE and ALU traffic is dropped.
  assign alloc_fire  = rdy_in && alloc_en && !clear_q && (count != DEPTH_CNT);
  assign wb_fire     = rdy_in && wb_en && !clear_q && valid_q[wb_tag];
  assign commit_fire = rdy_in && (count != '0) && valid_q[head] && ready_q[head];
  assign flush       = commit_fire && mis_q[head];

  rob_ptr_ctrl #(
    .DEPTH       (DEPTH),
    .TAG_W       (TAG_W),
    .FULL_MARGIN (FULL_MARGIN)
  ) u_ptr (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .alloc_fire  (alloc_fire),
    .commit_fire (commit_fire),
    .flush       (flush),
    .head        (head),
    .tail        (tail),
    .count       (count),
    .full        (rob_is_full)
  );

  always_comb begin
    valid_d  = valid_q;
    ready_d  = ready_q;
    mis_d    = mis_q;
    has_rd_d = has_rd_q;
    rd_d     = rd_q;
    val_d    = val_q;
    target_d = target_q;
    if (wb_fire) begin
      ready_d[wb_tag]  = ONE;
      val_d[wb_tag]    = wb_val;
      mis_d[wb_tag]    = wb_mispredict;
      target_d[wb_tag] = wb_target;
    end
    if (alloc_fire) begin
      valid_d[tail]  = ONE;
      ready_d[tail]  = ZERO;
      mis_d[tail]    = ZERO;
      rd_d[tail]     = alloc_rd;
      has_rd_d[tail] = alloc_has_rd;
    end
    if (commit_fire) valid_d[head] = ZERO;
    if (flush)       valid_d = '0;
  end

  always_comb begin
    commit_en_d     = commit_en_q;
    commit_num_d    = commit_num_q;
    commit_val_d    = commit_val_q;
    commit_rd_d     = commit_rd_q;
    commit_has_rd_d = commit_has_rd_q;
    clear_d         = clear_q;
    clear_pc_d      = clear_pc_q;
    if (rdy_in) begin
      commit_en_d = commit_fire;
      clear_d     = flush;
      if (commit_fire) begin
        commit_num_d    = head;
        commit_val_d    = val_q[head];
        commit_rd_d     = rd_q[head];
        commit_has_rd_d = has_rd_q[head];
      end
      if (flush) clear_pc_d = target_q[head];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q         <= '0;
      ready_q         <= '0;
      commit_en_q     <= ZERO;
      commit_num_q    <= '0;
      commit_val_q    <= '0;
      commit_rd_q     <= '0;
      commit_has_rd_q <= ZERO;
      clear_q         <= ZERO;
      clear_pc_q      <= '0;
    end else begin
      valid_q         <= valid_d;
      ready_q         <= ready_d;
      commit_en_q     <= commit_en_d;
      commit_num_q    <= commit_num_d;
      commit_val_q    <= commit_val_d;
      commit_rd_q     <= commit_rd_d;
      commit_has_rd_q <= commit_has_rd_d;
      clear_q         <= clear_d;
      clear_pc_q      <= clear_pc_d;
    end
  end

  // Payload is qualified by valid/ready, so it needs no reset.
  always_ff @(posedge clk_in) begin
    mis_q    <= mis_d;
    has_rd_q <= has_rd_d;
    rd_q     <= rd_d;
    val_q    <= val_d;
    target_q <= target_d;
  end

  assign alloc_tag     = tail;
  assign q1_ready      = valid_q[q1_tag] & ready_q[q1_tag];
  assign q2_ready      = valid_q[q2_tag] & ready_q[q2_tag];
  assign q1_val        = val_q[q1_tag];
  assign q2_val        = val_q[q2_tag];
  assign commit_en     = commit_en_q;
  assign commit_Number = commit_num_q;
  assign commit_val    = commit_val_q;
  assign commit_rd     = commit_rd_q;
  assign commit_has_rd = commit_has_rd_q;
  assign clear         = clear_q;
  assign clear_pc      = clear_pc_q;
endmodule
`default_nettype wire

// File: tb/tb_rob_commit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rob_commit : queue-based reference model with a commit scoreboard.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_rob_commit;
  localparam int DEPTH = 32;
  localparam int FULL_MARGIN = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b0;
  logic        alloc_en = 1'b0, alloc_has_rd = 1'b0;
  logic [4:0]  alloc_rd = '0, alloc_tag, q1_tag = '0, q2_tag = '0;
  logic        rob_is_full, q1_ready, q2_ready;
  logic [31:0] q1_val, q2_val;
  logic        wb_en = 1'b0, wb_mispredict = 1'b0;
  logic [4:0]  wb_tag = '0;
  logic [31:0] wb_val = '0, wb_target = '0;
  logic        commit_en, commit_has_rd, clear;
  logic [4:0]  commit_Number, commit_rd;
  logic [31:0] commit_val, clear_pc;

  rob_commit dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd), .alloc_has_rd(alloc_has_rd),
    .alloc_tag(alloc_tag), .rob_is_full(rob_is_full),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val),
    .wb_en(wb_en), .wb_tag(wb_tag), .wb_val(wb_val),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .commit_en(commit_en), .commit_Number(commit_Number), .commit_val(commit_val),
    .commit_rd(commit_rd), .commit_has_rd(commit_has_rd),
    .clear(clear), .clear_pc(clear_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [4:0] tag; logic [4:0] rd; bit hrd; bit rdy;
    logic [31:0] val; bit mis; logic [31:0] tgt;
  } ent_t;
  typedef struct {
    bit en; logic [4:0] tag; logic [31:0] val; logic [4:0] rd; bit hrd;
    bit clr; logic [31:0] pc;
  } exp_t;

  ent_t mq[$];        // live instructions, oldest first
  exp_t sb[$];        // expected outcome of each enabled edge
  logic [4:0] m_tail = '0;
  bit m_en = 0, m_clear = 0;
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic lookup(input logic [4:0] t, output bit r, output logic [31:0] v);
    r = 0; v = '0;
    foreach (mq[i]) if (mq[i].tag == t) begin r = mq[i].rdy; v = mq[i].val; end
  endtask

  task automatic check_state();
    bit r; logic [31:0] v;
    chk("alloc_tag", alloc_tag, m_tail);
    chk("count", dut.count, mq.size());
    chk("rob_is_full", rob_is_full, mq.size() >= DEPTH - FULL_MARGIN);
    lookup(q1_tag, r, v);
    chk("q1_ready", q1_ready, r);
    if (r) chk("q1_val", q1_val, v);
    lookup(q2_tag, r, v);
    chk("q2_ready", q2_ready, r);
    if (r) chk("q2_val", q2_val, v);
  endtask

  task automatic model_edge(input bit a_en, input logic [4:0] a_rd, input bit a_hrd,
                            input bit w_en, input logic [4:0] w_tag, input logic [31:0] w_val,
                            input bit w_mis, input logic [31:0] w_tgt, input bit rdy);
    exp_t x; ent_t n; int pre; bit fl;
    if (!rdy) begin
      chk("stall_commit_en", commit_en, m_en);
      chk("stall_clear", clear, m_clear);
      return;
    end
    x = '{default: '0};
    pre = mq.size();
    fl = 0;
    if (!m_clear) begin
      if (pre > 0 && mq[0].rdy) begin
        x.en = 1; x.tag = mq[0].tag; x.val = mq[0].val; x.rd = mq[0].rd; x.hrd = mq[0].hrd;
        if (mq[0].mis) begin fl = 1; x.clr = 1; x.pc = mq[0].tgt; end
        void'(mq.pop_front());
      end
      if (fl) begin
        mq.delete();
        m_tail = '0;
      end else begin
        if (w_en)
          foreach (mq[i])
            if (mq[i].tag == w_tag) begin
              mq[i].rdy = 1; mq[i].val = w_val; mq[i].mis = w_mis; mq[i].tgt = w_tgt;
            end
        if (a_en && pre < DEPTH) begin
          n.tag = m_tail; n.rd = a_rd; n.hrd = a_hrd; n.rdy = 0;
          n.val = '0; n.mis = 0; n.tgt = '0;
          mq.push_back(n);
          m_tail = m_tail + 5'd1;
        end
      end
    end
    sb.push_back(x);
    m_en = x.en;
    m_clear = x.clr;
  endtask

  task automatic step(input bit a_en, input logic [4:0] a_rd, input bit a_hrd,
                      input bit w_en, input logic [4:0] w_tag, input logic [31:0] w_val,
                      input bit w_mis, input logic [31:0] w_tgt, input bit rdy);
    @(negedge clk_in);
    alloc_en = a_en; alloc_rd = a_rd; alloc_has_rd = a_hrd;
    wb_en = w_en; wb_tag = w_tag; wb_val = w_val; wb_mispredict = w_mis; wb_target = w_tgt;
    rdy_in = rdy;
    q1_tag = 5'($urandom);
    q2_tag = (mq.size() > 0) ? mq[0].tag : 5'($urandom);
    #1;
    check_state();
    model_edge(a_en, a_rd, a_hrd, w_en, w_tag, w_val, w_mis, w_tgt, rdy);
  endtask

  task automatic do_alloc(input logic [4:0] rd);
    step(1, rd, rd != 5'd0, 0, '0, '0, 0, '0, 1);
  endtask
  task automatic do_wb(input logic [4:0] t, input logic [31:0] v, input bit mis, input logic [31:0] tgt);
    step(0, '0, 0, 1, t, v, mis, tgt, 1);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, '0, 0, '0, 1);
  endtask

  task automatic async_reset();
    @(negedge clk_in);
    alloc_en = 0; wb_en = 0;
    #2 rst_in = 1'b1;
    #1;
    chk("rst_count", dut.count, 0);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_commit_en", commit_en, 0);
    chk("rst_clear", clear, 0);
    chk("rst_full", rob_is_full, 0);
    mq.delete(); m_tail = '0; m_en = 0; m_clear = 0;
    @(negedge clk_in);
    rst_in = 1'b0;
    rdy_in = 1'b0;
  endtask

  // Scoreboard side: one expectation is consumed per enabled clock edge.
  initial begin : monitor
    bit en_s; exp_t e;
    forever begin
      @(posedge clk_in);
      en_s = rdy_in && !rst_in;
      @(negedge clk_in);
      if (en_s) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_underflow actual=edge required=no_edge at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("commit_en", commit_en, e.en);
          chk("clear", clear, e.clr);
          if (e.en) begin
            chk("commit_Number", commit_Number, e.tag);
            chk("commit_val", commit_val, e.val);
            chk("commit_rd", commit_rd, e.rd);
            chk("commit_has_rd", commit_has_rd, e.hrd);
          end
          if (e.clr) chk("clear_pc", clear_pc, e.pc);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    bit a, w, m;
    logic [4:0] t;
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset_commit_en", commit_en, 0);
    chk("reset_commit_Number", commit_Number, 0);
    chk("reset_commit_val", commit_val, 0);
    chk("reset_commit_rd", commit_rd, 0);
    chk("reset_commit_has_rd", commit_has_rd, 0);
    chk("reset_clear", clear, 0);
    chk("reset_clear_pc", clear_pc, 0);
    chk("reset_alloc_tag", alloc_tag, 0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Mid-run asynchronous reset with five live entries
    for (int i = 1; i <= 5; i++) do_alloc(5'(i));
    idle(1);
    chk("count_before_reset", dut.count, 5);
    async_reset();

    // Out-of-order write-back, in-order retire
    do_alloc(5'd1); do_alloc(5'd2); do_alloc(5'd3);
    do_wb(5'd2, 32'h33, 0, '0);
    do_wb(5'd0, 32'h11, 0, '0);
    do_wb(5'd1, 32'h22, 0, '0);
    idle(3);

    // Full threshold and tail wrap
    async_reset();
    for (int i = 0; i < 29; i++) do_alloc(5'(i + 1));
    do_alloc(5'd7);
    chk("full_at_29", rob_is_full, 0);
    idle(1);
    chk("full_at_30", rob_is_full, 1);
    for (int i = 0; i < 30; i++) do_wb(5'(i), 32'h100 + i, 0, '0);
    idle(2);
    for (int i = 0; i < 5; i++) do_alloc(5'(i + 9));
    for (int i = 0; i < 5; i++) do_wb(5'(30 + i), 32'h200 + i, 0, '0);
    idle(3);

    // Mispredicted retire flushes younger entries
    async_reset();
    for (int i = 0; i < 4; i++) do_alloc(5'(i + 4));
    do_wb(5'd1, 32'hB1, 1, 32'h1000);
    do_wb(5'd2, 32'hB2, 0, '0);
    do_wb(5'd3, 32'hB3, 0, '0);
    do_wb(5'd0, 32'hB0, 0, '0);
    idle(2);
    step(1, 5'd9, 1, 1, 5'd2, 32'hDEAD, 0, '0, 1);
    idle(1);
    chk("flush_alloc_tag", alloc_tag, 0);
    chk("flush_count", dut.count, 0);

    // Allocate and retire on the same edge; write-back to an invalid tag
    for (int i = 0; i < 4; i++) do_alloc(5'(i + 12));
    do_wb(5'd0, 32'h55, 0, '0);
    step(1, 5'd20, 1, 1, 5'd20, 32'hBAD, 0, '0, 1);
    idle(1);
    chk("simul_count", dut.count, 4);

    // Stall with the head ready, then a held pulse
    do_wb(5'd1, 32'h66, 0, '0);
    for (int i = 0; i < 3; i++) step(1, 5'd7, 1, 0, '0, '0, 0, '0, 0);
    idle(1);
    step(0, '0, 0, 0, '0, '0, 0, '0, 0);
    idle(2);

    // Randomized traffic: a filling phase then a draining phase
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 300; i++) begin
        a = ($urandom % 4) != 0;
        w = (ph == 0) ? (($urandom % 8) == 0) : (($urandom % 4) != 0);
        m = ($urandom % 24) == 0;
        if (mq.size() > 0 && ($urandom % 4) != 0) t = mq[$urandom % mq.size()].tag;
        else t = 5'($urandom);
        step(a, 5'($urandom), 1'($urandom), w, t, $urandom, m, $urandom, ($urandom % 8) != 0);
      end
    end
    idle(4);
    @(negedge clk_in);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer: the producing end of the commit broadcast that the reservation station consumes (commit_en / commit_Number / commit_val).
- Hands out ROB tags to ISSUE and accepts ALU write-backs.
- Retires entries strictly in program order, broadcasting each committed result to RS and the register file.
- Raises a one-cycle clear with a redirect PC when a mispredicted entry retires.

Parameters:
DEPTH, 32, number of entries; must be a power of two
TAG_W, 5, tag width; equals log2(DEPTH) and the shared RegAddrSize
FULL_MARGIN, 2, rob_is_full asserts when count >= DEPTH-FULL_MARGIN

Ports:
clk_in  in  1  clock
rst_in  in  1  reset, asynchronous, active-high
rdy_in  in  1  global enable; when low, all state and outputs hold
alloc_en  in  1  ISSUE allocates the entry at alloc_tag this cycle
alloc_rd  in  5  destination architectural register
alloc_has_rd  in  1  instruction writes rd
alloc_tag  out  TAG_W  tail index (combinational)
rob_is_full  out  1  combinational full flag
q1_tag, q2_tag  in  TAG_W  operand lookup tags from ISSUE
q1_ready, q2_ready  out  1  entry is valid and has a result (combinational)
q1_val, q2_val  out  32  entry result (combinational)
wb_en  in  1  ALU result valid
wb_tag  in  TAG_W  ROB tag of the result
wb_val  in  32  result value
wb_mispredict  in  1  branch resolved opposite to the prediction
wb_target  in  32  correct PC
commit_en  out  1  one-cycle commit pulse
commit_Number  out  TAG_W  tag being retired
commit_val  out  32  retired value
commit_rd  out  5  retired destination register
commit_has_rd  out  1  retired instruction writes rd
clear  out  1  one-cycle flush pulse to all units
clear_pc  out  32  redirect PC, valid while clear=1

Behaviour:
- Reset: head, tail, count = 0; all valid/ready bits = 0; commit_en, commit_Number, commit_val, commit_rd, commit_has_rd, clear, clear_pc = 0.
- Storage: per entry valid, ready, rd, has_rd, val, mispredict, target. Circular buffer; head and tail wrap modulo DEPTH.
- Allocate: alloc_en and count<DEPTH -> entry[tail] valid=1, ready=0, rd/has_rd captured; tail+1. alloc_en with count==DEPTH is ignored.
- Write-back: wb_en and valid[wb_tag] -> ready=1 and val/mispredict/target stored. A write-back to an invalid entry is ignored.
- Commit check: evaluated on each enabled edge. Condition is count>0, valid[head] and ready[head].
  - When it holds: register commit_en=1, commit_Number=head, commit_val, commit_rd, commit_has_rd; clear valid[head]; head+1.
  - Otherwise commit_en=0. Maximum one commit per cycle.
- Latency: wb at edge N -> ready at N -> commit_en high after edge N+1 (earliest).
- Same-cycle write-back to the head entry is not visible to the commit check until the next edge.
- Count: alloc-only +1; commit-only -1; alloc plus commit leaves count unchanged.
- Mispredict retire: when the committing entry has mispredict=1:
  - commit_en pulses as normal, and clear=1 with clear_pc=target on the same edge.
  - head, tail and count reset to 0 and all valid bits clear on that edge.
  - alloc_en and wb_en sampled while clear=1 are ignored.
  - clear drops on the next enabled edge.
- Lookup: qX_ready = valid[qX_tag] & ready[qX_tag]; qX_val = val[qX_tag]. This is pure read and does not bypass wb_* in the same cycle.
- rdy_in low: no state changes; pulses are held, not retriggered.
- rob_is_full is combinational from count, giving ISSUE FULL_MARGIN cycles of slack.

Decomposition:
- Shared def package: TAG_W / RegAddrSize, InstSize (32), the MAXN "no dependency" tag sentinel, zero/one constants.
- One sub-module, rob_ptr_ctrl: head/tail/count update, full flag, flush reset. Entry storage and the commit path stay in rob_commit.

Test Plan:
- Reset mid-run: assert rst_in asynchronously with count=5 -> count, alloc_tag, commit_en, clear all 0 before the next edge.
- In-order retire: allocate tags 0,1,2; wb tag2 val=0x33, tag0 val=0x11, tag1 val=0x22 -> commits in order 0(0x11), 1(0x22), 2(0x33) on consecutive cycles, never 2 first.
- Full/wrap: allocate 30 entries -> rob_is_full=1. Commit 30, then allocate 5 -> alloc_tag wraps 30,31,0,1,2 with correct commit_Number.
- Mispredict flush: tags 0-3 live; wb tag1 mispredict=1 target=0x1000 -> commit 0, then commit 1 with clear=1, clear_pc=0x1000; count=0; tags 2-3 never commit.
- Simultaneous: alloc and commit on the same edge at count=4 -> count stays 4. wb to an invalid tag -> no state change.
- Stall: hold rdy_in=0 for 3 cycles with the head ready -> commit_en unchanged; commit occurs on the first rdy_in=1 edge.
